// File: rtl/layer_seq_fsm.sv
// rtl/layer_seq_fsm.sv - CNN layer sequencer: unshuffle, then weight load + conv for three layers
// Drives the shared state bus, counts output channels, pulses acc_clr/frame_done.
module layer_seq_fsm #(
  parameter int CONV1_CH = 4,
  parameter int CONV2_CH = 12,
  parameter int CONV3_CH = 4,
  parameter int CH_W     = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            unshuffle_done,
  input  logic            load_done,
  input  logic            conv_done,
  output logic [3:0]      state,
  output logic [CH_W-1:0] ch_idx,
  output logic            acc_clr,
  output logic            busy,
  output logic            frame_done
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_UNSHUFFLE = 4'd1,
    S_LOAD1     = 4'd2,
    S_CONV1     = 4'd3,
    S_LOAD2     = 4'd4,
    S_CONV2     = 4'd5,
    S_LOAD3     = 4'd6,
    S_CONV3     = 4'd7,
    S_FINISH    = 4'd8
  } state_t;

  // Kept as a plain vector so illegal codes 9..15 are representable and recoverable.
  logic [3:0] state_r;

  function automatic logic [CH_W-1:0] last_ch(input logic [3:0] s);
    case (s)
      S_CONV1: last_ch = CH_W'(CONV1_CH - 1);
      S_CONV2: last_ch = CH_W'(CONV2_CH - 1);
      S_CONV3: last_ch = CH_W'(CONV3_CH - 1);
      default: last_ch = '0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      ch_idx     <= '0;
      acc_clr    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      acc_clr    <= 1'b0;
      frame_done <= 1'b0;
      case (state_r)
        S_IDLE: begin
          ch_idx <= '0;
          if (start) state_r <= S_UNSHUFFLE;
        end
        S_UNSHUFFLE: begin
          if (unshuffle_done) state_r <= S_LOAD1;
        end
        S_LOAD1, S_LOAD2, S_LOAD3: begin
          ch_idx <= '0;
          if (load_done) begin
            state_r <= state_r + 4'd1;
            acc_clr <= 1'b1;
          end
        end
        S_CONV1, S_CONV2, S_CONV3: begin
          if (conv_done) begin
            if (ch_idx == last_ch(state_r)) begin
              // CONV3 + 1 lands on FINISH, whose single cycle carries frame_done.
              state_r    <= state_r + 4'd1;
              ch_idx     <= '0;
              frame_done <= (state_r == S_CONV3);
            end else begin
              ch_idx  <= ch_idx + 1'b1;
              acc_clr <= 1'b1;
            end
          end
        end
        S_FINISH: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
          ch_idx  <= '0;
        end
      endcase
    end
  end

  assign state = state_r;
  assign busy  = (state_r != S_IDLE);

endmodule

// File: tb/tb_layer_seq_fsm.sv
// tb/tb_layer_seq_fsm.sv - directed + randomized bench for layer_seq_fsm with a phase-level model
module tb_layer_seq_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       unshuffle_done = 1'b0;
  logic       load_done = 1'b0;
  logic       conv_done = 1'b0;
  logic [3:0] state;
  logic [5:0] ch_idx;
  logic       acc_clr;
  logic       busy;
  logic       frame_done;

  int total = 0;
  int bad = 0;

  // Model: frame progress as a step number (0 idle .. 8 finish), channel count per layer.
  int m_step = 0;
  int m_ch = 0;
  bit m_acc = 0;
  bit m_fd = 0;
  int layer_ch [3] = '{4, 12, 4};

  int seq_q [$];
  int last_state = 0;
  int acc_cnt = 0;
  int fd_cnt = 0;

  layer_seq_fsm dut (
    .clk(clk), .rst(rst), .start(start), .unshuffle_done(unshuffle_done),
    .load_done(load_done), .conv_done(conv_done), .state(state), .ch_idx(ch_idx),
    .acc_clr(acc_clr), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit s, input bit u, input bit l, input bit c);
    m_acc = 0;
    m_fd = 0;
    if (r || m_step < 0 || m_step > 8) begin
      m_step = 0;
      m_ch = 0;
    end else if (m_step == 0) begin
      m_ch = 0;
      if (s) m_step = 1;
    end else if (m_step == 1) begin
      if (u) m_step = 2;
    end else if (m_step == 8) begin
      m_step = 0;
    end else if (m_step % 2 == 0) begin
      m_ch = 0;
      if (l) begin
        m_step++;
        m_acc = 1;
      end
    end else if (c) begin
      if (m_ch + 1 == layer_ch[(m_step - 3) / 2]) begin
        m_ch = 0;
        m_step++;
        m_fd = (m_step == 8);
      end else begin
        m_ch++;
        m_acc = 1;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit u, input bit l, input bit c);
    rst = r; start = s; unshuffle_done = u; load_done = l; conv_done = c;
    @(posedge clk);
    model_step(r, s, u, l, c);
    #1;
    chk("state", int'(state), m_step);
    chk("ch_idx", int'(ch_idx), m_ch);
    chk("acc_clr", int'(acc_clr), int'(m_acc));
    chk("frame_done", int'(frame_done), int'(m_fd));
    chk("busy", int'(busy), int'(m_step != 0));
    if (int'(state) != last_state) seq_q.push_back(int'(state));
    last_state = int'(state);
    if (acc_clr) acc_cnt++;
    if (frame_done) fd_cnt++;
    rst = 0; start = 0; unshuffle_done = 0; load_done = 0; conv_done = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic to_conv2(input int k);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, 1);
  endtask

  initial begin
    // T1: reset then start
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("reset_state", int'(state), 0);
    chk("reset_busy", int'(busy), 0);
    seq_q.delete();
    acc_cnt = 0;
    fd_cnt = 0;
    cyc(0, 1, 0, 0, 0);
    chk("t1_state", int'(state), 1);
    chk("t1_busy", int'(busy), 1);

    // T2: full frame with spec timing
    idle(9);
    cyc(0, 0, 1, 0, 0);
    for (int ly = 0; ly < 3; ly++) begin
      idle(3);
      cyc(0, 0, 0, 1, 0);
      for (int ch = 0; ch < layer_ch[ly]; ch++) begin
        idle(35);
        cyc(0, 0, 0, 0, 1);
      end
    end
    cyc(0, 0, 0, 0, 0);
    begin
      int exp_seq [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 0};
      chk("t2_seq_len", seq_q.size(), 9);
      for (int i = 0; i < 9 && i < seq_q.size(); i++) chk("t2_seq", seq_q[i], exp_seq[i]);
    end
    chk("t2_acc_clr_count", acc_cnt, 20);
    chk("t2_frame_done_count", fd_cnt, 1);

    // T3 + T4: ch_idx 5 -> 6 with acc_clr, last channel leaves, stray pulses ignored
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("t4_unshuffle_stray", int'(state), 1);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    chk("t4_load_in_conv1", int'(state), 3);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 1);
    chk("t3_load_and_conv", int'(ch_idx), 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0);
    chk("t4_start_in_conv2", int'(state), 5);
    cyc(0, 0, 0, 0, 1);
    chk("t3_ch6_state", int'(state), 5);
    chk("t3_ch6_idx", int'(ch_idx), 6);
    chk("t3_ch6_acc", int'(acc_clr), 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1);
    chk("t3_ch11", int'(ch_idx), 11);
    cyc(0, 0, 0, 0, 1);
    chk("t3_leave_state", int'(state), 6);
    chk("t3_leave_idx", int'(ch_idx), 0);
    cyc(1, 0, 0, 0, 0);

    // T5: reset in CONV2 at ch_idx 7, then clean frame
    to_conv2(7);
    chk("t5_pre_idx", int'(ch_idx), 7);
    cyc(1, 0, 0, 0, 0);
    chk("t5_state", int'(state), 0);
    chk("t5_acc", int'(acc_clr), 0);
    to_conv2(12);
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);
    chk("t5_finish", int'(frame_done), 1);
    cyc(0, 0, 0, 0, 0);

    // Randomized run
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 2) == 0));
    end

    // T6: illegal state code recovers to IDLE
    dut.state_r = 4'd12;
    m_step = 12;
    cyc(0, 0, 0, 0, 0);
    chk("t6_state", int'(state), 0);
    chk("t6_busy", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
